// File: rtl/stamp_write_scheduler_pkg.sv
// rtl/stamp_write_scheduler_pkg.sv - shared command codes, FSM encodings and command decode
package stamp_write_scheduler_pkg;

  // Command codes shared with the command unit
  localparam logic [3:0] CMD_NOP     = 4'h0;
  localparam logic [3:0] CMD_STAMP   = 4'h1;
  localparam logic [3:0] CMD_HOLD    = 4'h2;
  localparam logic [3:0] CMD_RELEASE = 4'h3;
  localparam logic [3:0] CMD_FINISH  = 4'hF;

  // Scheduler FSM encodings
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  typedef struct packed {
    logic stamp;
    logic hold;
    logic rel;
    logic finish;
  } cmd_dec_t;

  // Unknown codes decode to all-zero, i.e. behave as NOP
  function automatic cmd_dec_t decode_cmd(input logic [3:0] code);
    cmd_dec_t d;
    d.stamp  = (code == CMD_STAMP);
    d.hold   = (code == CMD_HOLD);
    d.rel    = (code == CMD_RELEASE);
    d.finish = (code == CMD_FINISH);
    return d;
  endfunction

endpackage

// File: rtl/stamp_write_scheduler_if.sv
// rtl/stamp_write_scheduler_if.sv - memory write request channel
interface stamp_write_scheduler_if #(
  parameter int TS_W = 64
) ();
  logic            wr_valid;
  logic            wr_ready;
  logic [63:0]     wr_addr;
  logic [TS_W-1:0] wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/stamp_fifo.sv
// rtl/stamp_fifo.sv - timestamp FIFO with registered head entry
module stamp_fifo #(
  parameter int DEPTH = 16,
  parameter int TS_W  = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_push,
  input  logic            i_pop,
  input  logic [TS_W-1:0] i_din,
  output logic [TS_W-1:0] o_head,
  output logic            o_full,
  output logic            o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [TS_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]   r_rd_ptr;
  logic [AW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;
  logic [TS_W-1:0] r_head;
  logic [AW-1:0]   w_rd_next;

  assign w_rd_next = r_rd_ptr + AW'(1);
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_head    = r_head;

  // Storage array; contents are don't-care until counted as valid, so no reset
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_din;
  end

  // Pointers, occupancy and head register; a push into an empty (or emptying) FIFO bypasses into the head
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= w_rd_next;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (i_pop) begin
        if (r_count == CW'(1)) begin
          if (i_push) r_head <= i_din;
        end else begin
          r_head <= r_mem[w_rd_next];
        end
      end else if (i_push && (r_count == '0)) begin
        r_head <= i_din;
      end
    end
  end
endmodule

// File: rtl/stamp_write_scheduler.sv
// rtl/stamp_write_scheduler.sv - buffers cycle-count timestamps and writes them to memory in order
module stamp_write_scheduler
  import stamp_write_scheduler_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int TS_W  = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     done,
  input  logic [3:0]               command,
  input  logic [63:0]              base_addr,
  stamp_write_scheduler_if.master  wr,
  output logic [31:0]              stamp_count,
  output logic                     overflow
);
  logic [1:0]      r_state;
  logic [TS_W-1:0] r_cnt;
  logic [63:0]     r_base;
  logic [31:0]     r_stamp_count;
  logic            r_overflow;
  logic            r_hold;
  logic            r_lock;

  cmd_dec_t        w_cmd;
  logic            w_start_ok;
  logic            w_run;
  logic            w_drain;
  logic            w_wr_valid;
  logic            w_pop;
  logic            w_push_req;
  logic            w_push;
  logic            w_drop;
  logic            w_full;
  logic            w_empty;
  logic [TS_W-1:0] w_head;

  assign w_cmd      = decode_cmd(command);
  assign w_start_ok = (r_state == ST_IDLE) && start;
  assign w_run      = (r_state == ST_RUN);
  assign w_drain    = (r_state == ST_DRAIN);

  // r_lock keeps an offered write up through a stall even if HOLD lands meanwhile
  assign w_wr_valid = !w_empty && (r_lock || (w_run && !r_hold) || w_drain);
  assign w_pop      = w_wr_valid && wr.wr_ready;
  assign w_push_req = w_run && w_cmd.stamp;
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_drop     = w_push_req && !w_push;

  assign done        = (r_state == ST_IDLE);
  assign wr.wr_valid = w_wr_valid;
  assign wr.wr_data  = w_head;
  assign wr.wr_addr  = r_base + {29'd0, r_stamp_count, 3'b000};
  assign stamp_count = r_stamp_count;
  assign overflow    = r_overflow;

  stamp_fifo #(
    .DEPTH (DEPTH),
    .TS_W  (TS_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (r_cnt),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Session FSM: start opens a run, FINISH drains, an empty FIFO closes the session
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (start) r_state <= ST_RUN;
        ST_RUN:   if (w_cmd.finish) r_state <= ST_DRAIN;
        ST_DRAIN: if (w_empty) r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  // Timestamp counter restarts at zero on each accepted start and otherwise free-runs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_cnt <= '0;
    else if (w_start_ok) r_cnt <= '0;
    else                 r_cnt <= r_cnt + TS_W'(1);
  end

  // Session registers: base address, completed-write count and sticky drop flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base        <= '0;
      r_stamp_count <= '0;
      r_overflow    <= 1'b0;
    end else if (w_start_ok) begin
      r_base        <= base_addr;
      r_stamp_count <= '0;
      r_overflow    <= 1'b0;
    end else begin
      if (w_pop)  r_stamp_count <= r_stamp_count + 32'd1;
      if (w_drop) r_overflow    <= 1'b1;
    end
  end

  // Hold flag follows HOLD/RELEASE in RUN; FINISH and a new session clear it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        r_hold <= 1'b0;
    else if (w_start_ok)               r_hold <= 1'b0;
    else if (w_run && w_cmd.finish)    r_hold <= 1'b0;
    else if (w_run && w_cmd.hold)      r_hold <= 1'b1;
    else if (w_run && w_cmd.rel)       r_hold <= 1'b0;
  end

  // Remember that a write is being offered but not yet taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_lock <= 1'b0;
    else        r_lock <= w_wr_valid && !wr.wr_ready;
  end
endmodule

// File: doc/stamp_write_scheduler.md
STAMP_WRITE_SCHEDULER -- requirements
Module: stamp_write_scheduler

Interface
REQ-001 SHALL have parameter DEPTH, default 16, timestamp FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter TS_W, default 64, timestamp and write-data width.
REQ-003 SHALL have port clk  input  1  sole clock; all logic rising-edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port start  input  1  begin session; sampled only in IDLE.
REQ-006 SHALL have port done  output  1  high in IDLE.
REQ-007 SHALL have port command  input  4  per-cycle command from command unit; 0x0 when none.
REQ-008 SHALL have port base_addr  input  64  byte address of timestamp buffer; sampled on accepted start.
REQ-009 SHALL have ports wr_valid (output, 1), wr_ready (input, 1), wr_addr (output, 64), wr_data (output, TS_W): memory write request channel.
REQ-010 SHALL have port stamp_count  output  32  number of completed writes this session.
REQ-011 SHALL have port overflow  output  1  sticky; a STAMP was dropped this session.

Function
REQ-012 SHALL decode commands: NOP 0x0, STAMP 0x1, HOLD 0x2, RELEASE 0x3, FINISH 0xF; other codes act as NOP.
REQ-013 SHALL implement FSM IDLE -> RUN (start) -> DRAIN (FINISH) -> IDLE (FIFO empty, no write outstanding).
REQ-014 SHALL ignore command in IDLE and DRAIN; SHALL ignore start outside IDLE.
REQ-015 SHALL run a free-running TS_W-bit cycle counter, cleared to 0 on accepted start, incrementing every cycle thereafter, wrapping modulo 2^TS_W.
REQ-016 SHALL, on STAMP in RUN at cycle N, push counter value of cycle N; earliest resulting wr_valid at N+1.
REQ-017 SHALL accept a push when FIFO not full, or full with a pop (wr_valid&&wr_ready) in the same cycle; otherwise drop it and set overflow.
REQ-018 SHALL set hold flag on HOLD and clear it on RELEASE; both idempotent; FINISH clears hold.
REQ-019 SHALL assert wr_valid only when FIFO non-empty and (state RUN with hold clear, or state DRAIN).
REQ-020 SHALL, once wr_valid is high, keep it high with wr_addr/wr_data stable until wr_ready; HOLD arriving meanwhile takes effect after that handshake.
REQ-021 SHALL drive wr_data = FIFO head, wr_addr = base_addr + 8*stamp_count (64-bit, wrapping).
REQ-022 SHALL increment stamp_count on each wr_valid&&wr_ready, wrapping modulo 2^32.
REQ-023 SHALL drain FIFO in strict push order; back-to-back writes at one per cycle when wr_ready held high.
REQ-024 SHALL keep stamp_count and overflow readable in IDLE until next accepted start clears them.
REQ-025 SHALL treat STAMP and FINISH as mutually exclusive per cycle (one command code); FINISH pushes nothing.

Reset
REQ-026 SHALL, on rst_n low at any time, asynchronously force: state IDLE, done 1, wr_valid 0, wr_addr 0, wr_data 0, stamp_count 0, overflow 0, hold 0, FIFO empty, counter 0.
REQ-027 SHALL discard buffered and in-flight writes on reset mid-operation; no write completes after reset.

Structure
REQ-028 SHALL take command codes and FSM state encodings from the shared commands package/header used by the command unit.
REQ-029 SHALL implement the FIFO as one sub-module, stamp_fifo (DEPTH x TS_W, push/pop/full/empty, registered head).

Verification
REQ-030 SHALL test: start, STAMP at counter values 5 and 9, wr_ready=1 -> writes (base,5),(base+8,9), stamp_count=2.
REQ-031 SHALL test: HOLD, 3 STAMPs, 20 idle cycles -> wr_valid stays 0; RELEASE -> 3 writes in order at base, base+8, base+16.
REQ-032 SHALL test: DEPTH=16, hold set, 17 STAMPs -> 16 buffered, overflow=1; FINISH -> 16 writes, then done=1.
REQ-033 SHALL test: wr_ready=0 for 10 cycles with wr_valid high, HOLD mid-stall -> addr/data stable; write completes when wr_ready=1; next write waits for RELEASE.
REQ-034 SHALL test: rst_n low while 4 entries pending -> all outputs at reset values immediately, zero further writes.
REQ-035 SHALL test: full FIFO with wr_ready=1 and STAMP same cycle -> push accepted, overflow stays 0.
